// File: rtl/riscv_soft_alu_issue.sv
// ID/EX pipeline register and operand-issue stage feeding the ALU.
// Resolves rs1/rs2 through EX/WB bypass, selects PC/immediate operands,
// inserts a single bubble on load-use and honours backpressure and flush.
module riscv_soft_alu_issue #(
    parameter int XPR_LEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [3:0]         id_alu_op,
    input  logic [4:0]         id_rs1_addr,
    input  logic [4:0]         id_rs2_addr,
    input  logic [XPR_LEN-1:0] id_rs1_data,
    input  logic [XPR_LEN-1:0] id_rs2_data,
    input  logic [XPR_LEN-1:0] id_pc,
    input  logic [XPR_LEN-1:0] id_imm,
    input  logic               id_use_pc,
    input  logic               id_use_imm,
    input  logic [4:0]         id_rd_addr,
    input  logic               id_wen,
    input  logic               id_is_load,
    input  logic [XPR_LEN-1:0] ex_alu_result,
    input  logic               wb_wen,
    input  logic [4:0]         wb_rd_addr,
    input  logic [XPR_LEN-1:0] wb_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [3:0]         ex_alu_op,
    output logic [XPR_LEN-1:0] ex_operand_1,
    output logic [XPR_LEN-1:0] ex_operand_2,
    output logic [4:0]         ex_rd_addr,
    output logic               ex_wen,
    output logic               ex_is_load
);

    logic               ex_valid_q,   ex_valid_d;
    logic [3:0]         ex_alu_op_q,  ex_alu_op_d;
    logic [XPR_LEN-1:0] ex_op1_q,     ex_op1_d;
    logic [XPR_LEN-1:0] ex_op2_q,     ex_op2_d;
    logic [4:0]         ex_rd_addr_q, ex_rd_addr_d;
    logic               ex_wen_q,     ex_wen_d;
    logic               ex_is_load_q, ex_is_load_d;

    logic               adv;
    logic               hazard;
    logic               transfer;
    logic [XPR_LEN-1:0] fwd_rs1;
    logic [XPR_LEN-1:0] fwd_rs2;

    // Handshake: EX can take a new instruction when empty or draining; a load
    // in EX whose result a real source operand needs forces one bubble.
    always_comb begin
        adv      = !ex_valid_q || ex_ready;
        hazard   = ex_valid_q && ex_is_load_q && ex_wen_q && (ex_rd_addr_q != 5'd0) &&
                   ((!id_use_pc  && (id_rs1_addr == ex_rd_addr_q)) ||
                    (!id_use_imm && (id_rs2_addr == ex_rd_addr_q)));
        id_ready = adv && !hazard && !flush;
        transfer = id_valid && id_ready;
    end

    // Bypass network: x0 is hardwired, EX (younger) beats WB, then regfile.
    // Loads in EX never forward since their data is not known yet.
    always_comb begin
        if (id_rs1_addr == 5'd0)
            fwd_rs1 = '0;
        else if (ex_valid_q && ex_wen_q && !ex_is_load_q && (ex_rd_addr_q == id_rs1_addr))
            fwd_rs1 = ex_alu_result;
        else if (wb_wen && (wb_rd_addr == id_rs1_addr))
            fwd_rs1 = wb_data;
        else
            fwd_rs1 = id_rs1_data;

        if (id_rs2_addr == 5'd0)
            fwd_rs2 = '0;
        else if (ex_valid_q && ex_wen_q && !ex_is_load_q && (ex_rd_addr_q == id_rs2_addr))
            fwd_rs2 = ex_alu_result;
        else if (wb_wen && (wb_rd_addr == id_rs2_addr))
            fwd_rs2 = wb_data;
        else
            fwd_rs2 = id_rs2_data;
    end

    // Next-state for the EX register: flush kills, stall holds, otherwise load
    // on transfer or bubble. Payload is left untouched when nothing is loaded.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_wen_d     = ex_wen_q;
        ex_is_load_d = ex_is_load_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d = transfer;
            if (transfer) begin
                ex_alu_op_d  = id_alu_op;
                ex_op1_d     = id_use_pc  ? id_pc  : fwd_rs1;
                ex_op2_d     = id_use_imm ? id_imm : fwd_rs2;
                ex_rd_addr_d = id_rd_addr;
                ex_wen_d     = id_wen;
                ex_is_load_d = id_is_load;
            end
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_alu_op_q  <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_rd_addr_q <= '0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            ex_wen_q     <= ex_wen_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_operand_1 = ex_op1_q;
    assign ex_operand_2 = ex_op2_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign ex_wen       = ex_wen_q;
    assign ex_is_load   = ex_is_load_q;

endmodule
